// File: rtl/mem_port_arbiter_if.sv
// Fetch-port, data-port and memory-side signals around mem_port_arbiter.
// slave is the arbiter's own view; master is the view of the stages and memory around it.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [79:0] if_rdata;
  logic        if_err;

  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        dm_err;

  logic        mem_req;
  logic        mem_we;
  logic        mem_size;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [79:0] mem_rdata;
  logic        mem_err;

  logic        busy;
  logic        gnt_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ack, mem_rdata, mem_err,
    output if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata, busy, gnt_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ack, mem_rdata, mem_err,
    input  if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata, busy, gnt_dm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch port (10-byte reads) and the
// data port (8-byte read/write): data-priority arbitration, fetch anti-starvation, bounds check, timeout.
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES  = 8192,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned    SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned    WW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [WW-1:0]  WAIT_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [64:0]    MEM_LIMIT  = 65'(MEM_BYTES);
  localparam bit             TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [WW-1:0] wait_reg, wait_next;
  logic          gnt_dm_reg, gnt_dm_next;
  logic          we_reg, we_next;
  logic          size_reg, size_next;
  logic [63:0]   addr_reg, addr_next;
  logic [63:0]   wdata_reg, wdata_next;
  logic [79:0]   if_rdata_reg, if_rdata_next;
  logic [63:0]   dm_rdata_reg, dm_rdata_next;
  logic          if_err_reg, if_err_next;
  logic          dm_err_reg, dm_err_next;
  logic          mem_req_reg, mem_we_reg, if_ack_reg, dm_ack_reg, busy_reg;

  logic          pick_if;
  logic [63:0]   req_addr;
  logic [64:0]   req_end;
  logic          req_oob;
  logic          resp_now;
  logic          resp_err;
  logic [79:0]   resp_rdata;

  // The extra top bit keeps addresses near 2^64 from wrapping back in bounds.
  assign pick_if  = bus.if_req && (!bus.dm_req || (starve_reg == STARVE_TOP));
  assign req_addr = pick_if ? bus.if_addr : bus.dm_addr;
  assign req_end  = {1'b0, req_addr} + (pick_if ? 65'd10 : 65'd8);
  assign req_oob  = req_end > MEM_LIMIT;

  always_comb begin
    state_next    = state_reg;
    starve_next   = starve_reg;
    wait_next     = wait_reg;
    gnt_dm_next   = gnt_dm_reg;
    we_next       = we_reg;
    size_next     = size_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
    if_err_next   = if_err_reg;
    dm_err_next   = dm_err_reg;
    resp_now      = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (!bus.if_req) begin
          starve_next = '0;
        end
        if (bus.if_req || bus.dm_req) begin
          gnt_dm_next = !pick_if;
          we_next     = !pick_if && bus.dm_we;
          size_next   = pick_if;
          addr_next   = req_addr;
          wdata_next  = bus.dm_wdata;
          wait_next   = '0;
          if (pick_if) begin
            starve_next = '0;
          end else if (bus.if_req && (starve_reg != STARVE_TOP)) begin
            starve_next = starve_reg + SW'(1);
          end
          if (req_oob) begin
            state_next = ST_RESP;
            resp_now   = 1'b1;
            resp_err   = 1'b1;
          end else begin
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        wait_next = wait_reg + WW'(1);
        if (bus.mem_ack) begin
          state_next = ST_RESP;
          resp_now   = 1'b1;
          resp_err   = bus.mem_err;
          resp_rdata = bus.mem_rdata;
        end else if (TIMEOUT_EN && (wait_reg == WAIT_LAST)) begin
          state_next = ST_RESP;
          resp_now   = 1'b1;
          resp_err   = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Read data is zeroed whenever the access failed, and for data-port writes.
    if (resp_now) begin
      if (gnt_dm_next) begin
        dm_err_next   = resp_err;
        dm_rdata_next = (resp_err || we_next) ? 64'd0 : resp_rdata[63:0];
      end else begin
        if_err_next   = resp_err;
        if_rdata_next = resp_err ? 80'd0 : resp_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      starve_reg   <= '0;
      wait_reg     <= '0;
      gnt_dm_reg   <= 1'b0;
      we_reg       <= 1'b0;
      size_reg     <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
      if_err_reg   <= 1'b0;
      dm_err_reg   <= 1'b0;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      if_ack_reg   <= 1'b0;
      dm_ack_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      starve_reg   <= starve_next;
      wait_reg     <= wait_next;
      gnt_dm_reg   <= gnt_dm_next;
      we_reg       <= we_next;
      size_reg     <= size_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
      if_err_reg   <= if_err_next;
      dm_err_reg   <= dm_err_next;
      mem_req_reg  <= (state_next == ST_BUSY);
      mem_we_reg   <= (state_next == ST_BUSY) && we_next;
      if_ack_reg   <= resp_now && !gnt_dm_next;
      dm_ack_reg   <= resp_now && gnt_dm_next;
      busy_reg     <= (state_next != ST_IDLE);
    end
  end

  assign bus.if_ack    = if_ack_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.if_err    = if_err_reg;
  assign bus.dm_ack    = dm_ack_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.dm_err    = dm_err_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_size  = size_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.busy      = busy_reg;
  assign bus.gnt_dm    = gnt_dm_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: the bench plays both pipeline stages and the memory,
// and predicts each response from a transaction-level model of arbitration, bounds and timeout.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int MEM_BYTES  = 8192;
  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 16;
  localparam int NO_ACK     = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_BYTES (MEM_BYTES),
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } req_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_tx     = 0;

  logic [7:0] mem_model [0:MEM_BYTES-1];

  req_t if_q[$], dm_q[$];
  req_t if_cur, dm_cur;
  logic if_out = 1'b0, dm_out = 1'b0;
  int   if_iss = 0, dm_iss = 0;
  int   if_issued = 0, dm_issued = 0, if_done = 0, dm_done = 0;
  int   starve_m = 0;

  int          lat_mode = 0;   // -1 random, otherwise fixed wait before mem_ack
  int          inj_mode = 0;   // 0 none, 1 random, 2 force on next access
  bit          chk_lat  = 1'b0;
  int          lat_cur = 0, req_cycles = 0, last_req_cyc = 0;
  logic        inj_cur = 1'b0, to_cur = 1'b0, late_pulse = 1'b0;
  logic [63:0] seen_addr, seen_wdata;
  logic        seen_we, seen_size;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [79:0] mem_bytes(input logic [63:0] a, input int n);
    logic [79:0] r;
    logic [63:0] t;
    r = '0;
    for (int i = 0; i < n; i++) begin
      t = a + 64'(i);
      r[8*i +: 8] = mem_model[t[12:0]];
    end
    return r;
  endfunction

  function automatic logic oob(input logic [63:0] a, input int n);
    return ({1'b0, a} + 65'(n)) > 65'(MEM_BYTES);
  endfunction

  function automatic logic [63:0] rand_addr(input int nb);
    logic [63:0] a;
    case ($urandom_range(0, 9))
      0:       a = 64'(MEM_BYTES - nb);
      1:       a = 64'(MEM_BYTES - nb + 1);
      2:       a = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
      default: a = 64'($urandom_range(0, MEM_BYTES - nb));
    endcase
    return a;
  endfunction

  task automatic issue_next(input int port);
    if (port == 0) begin
      if (if_q.size() > 0) begin
        if_cur = if_q.pop_front();
        if_out = 1'b1; if_iss = cyc; if_issued++;
      end else begin
        if_out = 1'b0;
      end
      bus.if_req  = if_out;
      bus.if_addr = if_cur.addr;
    end else begin
      if (dm_q.size() > 0) begin
        dm_cur = dm_q.pop_front();
        dm_out = 1'b1; dm_iss = cyc; dm_issued++;
      end else begin
        dm_out = 1'b0;
      end
      bus.dm_req   = dm_out;
      bus.dm_we    = dm_cur.we;
      bus.dm_addr  = dm_cur.addr;
      bus.dm_wdata = dm_cur.wdata;
    end
  endtask

  task automatic monitor_ack();
    int          got_port, exp_port, nb;
    req_t        r;
    logic        bad, exp_err;
    logic [79:0] exp_rd;
    got_port = bus.dm_ack ? 1 : 0;
    check("one_ack", 80'(bus.if_ack & bus.dm_ack), 80'd0);
    // Data wins unless fetch is alone or has waited out STARVE_MAX data grants.
    if (if_out && (!dm_out || starve_m == STARVE_MAX)) begin
      exp_port = 0; starve_m = 0;
    end else begin
      exp_port = 1;
      starve_m = if_out ? ((starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX) : 0;
    end
    check("grant_port", 80'(got_port), 80'(exp_port));
    check("gnt_dm", 80'(bus.gnt_dm), 80'(got_port));
    check("busy_resp", 80'(bus.busy), 80'd1);
    check("outstanding", 80'(got_port ? dm_out : if_out), 80'd1);
    r       = got_port ? dm_cur : if_cur;
    nb      = got_port ? 8 : 10;
    bad     = oob(r.addr, nb);
    exp_err = bad | inj_cur | to_cur;
    if (!bad) begin
      check("mem_addr", 80'(seen_addr), 80'(r.addr));
      check("mem_we", 80'(seen_we), 80'(r.we));
      check("mem_size", 80'(seen_size), 80'(got_port == 0));
      if (r.we) check("mem_wdata", 80'(seen_wdata), 80'(r.wdata));
      check("req_cycles", 80'(req_cycles), 80'(to_cur ? TIMEOUT : lat_cur + 1));
      check("ack_latency", 80'(cyc), 80'(last_req_cyc + 1));
      if (chk_lat) check("total_latency", 80'(cyc - (got_port ? dm_iss : if_iss)), 80'(lat_cur + 2));
    end else begin
      check("no_mem_req", 80'(req_cycles), 80'd0);
    end
    if (got_port == 1) begin
      exp_rd = (exp_err || r.we) ? 80'd0 : mem_bytes(r.addr, 8);
      check("dm_err", 80'(bus.dm_err), 80'(exp_err));
      check("dm_rdata", 80'(bus.dm_rdata), exp_rd);
    end else begin
      check("if_err", 80'(bus.if_err), 80'(exp_err));
      if (!exp_err) check("if_rdata", bus.if_rdata, mem_bytes(r.addr, 10));
    end
    n_tx++;
    $display("tx %0d port=%s we=%0d addr=%h err=%0d wait=%0d", n_tx, got_port ? "dm" : "if",
             r.we, r.addr, exp_err, req_cycles);
    late_pulse = to_cur;
    req_cycles = 0; inj_cur = 1'b0; to_cur = 1'b0;
    if (got_port == 1) begin dm_done++; issue_next(1); end
    else begin if_done++; issue_next(0); end
  endtask

  task automatic respond();
    logic [63:0] t;
    if (late_pulse) begin
      // A completion arriving after the timeout fired must be ignored.
      bus.mem_ack   = 1'b1;
      bus.mem_err   = 1'b1;
      bus.mem_rdata = 80'({$urandom(), $urandom(), $urandom()});
      late_pulse    = 1'b0;
    end else if (bus.mem_req) begin
      if (req_cycles == 0) begin
        seen_addr = bus.mem_addr; seen_we = bus.mem_we;
        seen_size = bus.mem_size; seen_wdata = bus.mem_wdata;
        if (lat_mode < 0) lat_cur = ($urandom_range(0, 19) == 0) ? TIMEOUT + 4 : $urandom_range(0, 3);
        else lat_cur = lat_mode;
        to_cur  = (lat_cur >= TIMEOUT);
        inj_cur = (inj_mode == 2) || ((inj_mode == 1) && ($urandom_range(0, 7) == 0));
        if (inj_mode == 2) inj_mode = 0;
      end
      req_cycles++;
      last_req_cyc = cyc;
      if (req_cycles == lat_cur + 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_err   = inj_cur;
        bus.mem_rdata = mem_bytes(bus.mem_addr, 10);
        if (bus.mem_we && !inj_cur) begin
          for (int i = 0; i < 8; i++) begin
            t = bus.mem_addr + 64'(i);
            mem_model[t[12:0]] = bus.mem_wdata[8*i +: 8];
          end
        end
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_err   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 80'({$urandom(), $urandom(), $urandom()});
      end
    end else begin
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.if_ack || bus.dm_ack) monitor_ack();
    respond();
  endtask

  task automatic run_round(input int budget);
    int left;
    left = budget;
    if (!if_out) issue_next(0);
    if (!dm_out) issue_next(1);
    while ((if_out || dm_out) && left > 0) begin
      step();
      left--;
    end
    check("round_done", 80'(if_out | dm_out), 80'd0);
    if_q.delete(); dm_q.delete();
    if_out = 1'b0; dm_out = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    repeat (3) step();
    starve_m = 0;
  endtask

  task automatic push_if(input logic [63:0] a);
    req_t r;
    r.addr = a; r.we = 1'b0; r.wdata = '0;
    if_q.push_back(r);
  endtask

  task automatic push_dm(input logic [63:0] a, input logic we, input logic [63:0] d);
    req_t r;
    r.addr = a; r.we = we; r.wdata = d;
    dm_q.push_back(r);
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem_model[i] = 8'($urandom());
    if_cur = '{64'd0, 1'b0, 64'd0};
    dm_cur = '{64'd0, 1'b0, 64'd0};
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = '0;

    repeat (2) @(negedge clk);
    check("rst_mem_req", 80'(bus.mem_req), 80'd0);
    check("rst_acks", 80'({bus.if_ack, bus.dm_ack}), 80'd0);
    check("rst_busy_gnt", 80'({bus.busy, bus.gnt_dm}), 80'd0);
    check("rst_if_rdata", bus.if_rdata, 80'd0);
    check("rst_dm_rdata_err", 80'({bus.dm_rdata, bus.dm_err, bus.if_err}), 80'd0);
    rst_n = 1'b1;
    step();

    // Zero-wait fetch from address 0: mem_req one cycle after the request, ack one later.
    lat_mode = 0; inj_mode = 0; chk_lat = 1'b1;
    push_if(64'd0);
    run_round(20);
    chk_lat = 1'b0;

    // Both ports held, 2-cycle memory: fetch gets every fourth grant.
    lat_mode = 1;
    for (int i = 0; i < 2; i++) push_if(64'(16 * i + 32));
    for (int i = 0; i < 6; i++) push_dm(64'(8 * i + 256), 1'b0, '0);
    run_round(100);

    // Write at the last legal slot, one byte past it, then read the slot back.
    lat_mode = 0;
    push_dm(64'd8184, 1'b1, 64'h0123_4567_89AB_CDEF);
    push_dm(64'd8185, 1'b1, 64'hDEAD_BEEF_0000_0001);
    push_dm(64'd8184, 1'b0, '0);
    run_round(40);

    // Withheld memory ack: timeout after TIMEOUT cycles, then a late ack.
    lat_mode = NO_ACK;
    push_dm(64'd128, 1'b0, '0);
    run_round(60);

    // Reset while BUSY abandons the access; the still-held request is served afterwards.
    lat_mode = NO_ACK;
    push_dm(64'd64, 1'b0, '0);
    issue_next(1);
    repeat (3) step();
    check("busy_before_rst", 80'(bus.mem_req), 80'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_drops_mem_req", 80'(bus.mem_req), 80'd0);
    check("rst_drops_busy", 80'(bus.busy), 80'd0);
    req_cycles = 0; late_pulse = 1'b0; starve_m = 0; lat_mode = 0;
    repeat (2) begin
      step();
      check("rst_no_ack", 80'({bus.if_ack, bus.dm_ack}), 80'd0);
    end
    rst_n = 1'b1;
    run_round(40);

    // Memory fault on a fetch, then a clean data read.
    lat_mode = 1; inj_mode = 2;
    push_if(64'd512);
    run_round(20);
    inj_mode = 0;
    push_dm(64'd520, 1'b0, '0);
    run_round(20);

    // Randomized rounds: mixed ports, addresses, latencies, faults and timeouts.
    lat_mode = -1; inj_mode = 1;
    for (int rnd = 0; rnd < 25; rnd++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode != 2) repeat ($urandom_range(2, 6)) push_if(rand_addr(10));
      if (mode != 1) repeat ($urandom_range(2, 6))
        push_dm(rand_addr(8), 1'($urandom_range(0, 1)), {$urandom(), $urandom()});
      run_round(800);
    end

    check("if_all_acked", 80'(if_done), 80'(if_issued));
    check("dm_all_acked", 80'(dm_done), 80'(dm_issued));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "bench time limit reached");
  end
endmodule
